// File: rtl/hpu_lsu_lsq_if.sv
// Bundle of the LSQ's enqueue, D-cache, wake-up, write-back and exception signals.
// Signal suffixes are from the LSQ's point of view. The LSQ uses the slave modport
// and the surrounding pipeline uses the master modport.
interface hpu_lsu_lsq_if #(
  parameter int PHY_IDX_W = 6
);

  logic                 flush_en_i;
  logic                 lsq_en_i;
  logic                 lsq_store_i;
  logic [1:0]           lsq_size_i;
  logic                 lsq_unsigned_i;
  logic [31:0]          lsq_addr_i;
  logic [31:0]          lsq_wdata_i;
  logic [PHY_IDX_W-1:0] lsq_rdst_index_i;
  logic                 lsq_stall_o;

  logic                 dc_req_o;
  logic                 dc_we_o;
  logic [31:0]          dc_addr_o;
  logic [31:0]          dc_wdata_o;
  logic [3:0]           dc_be_o;
  logic                 dc_ack_i;
  logic                 dc_rvld_i;
  logic [31:0]          dc_rdata_i;

  logic                 laq_awake_en_o;
  logic [PHY_IDX_W-1:0] laq_awake_rdst_index_o;
  logic                 wb_en_o;
  logic [PHY_IDX_W-1:0] wb_rdst_index_o;
  logic [31:0]          wb_data_o;
  logic                 misalign_o;
  logic [31:0]          misalign_addr_o;

  modport slave (
    input  flush_en_i, lsq_en_i, lsq_store_i, lsq_size_i, lsq_unsigned_i,
           lsq_addr_i, lsq_wdata_i, lsq_rdst_index_i,
           dc_ack_i, dc_rvld_i, dc_rdata_i,
    output lsq_stall_o, dc_req_o, dc_we_o, dc_addr_o, dc_wdata_o, dc_be_o,
           laq_awake_en_o, laq_awake_rdst_index_o,
           wb_en_o, wb_rdst_index_o, wb_data_o,
           misalign_o, misalign_addr_o
  );

  modport master (
    output flush_en_i, lsq_en_i, lsq_store_i, lsq_size_i, lsq_unsigned_i,
           lsq_addr_i, lsq_wdata_i, lsq_rdst_index_i,
           dc_ack_i, dc_rvld_i, dc_rdata_i,
    input  lsq_stall_o, dc_req_o, dc_we_o, dc_addr_o, dc_wdata_o, dc_be_o,
           laq_awake_en_o, laq_awake_rdst_index_o,
           wb_en_o, wb_rdst_index_o, wb_data_o,
           misalign_o, misalign_addr_o
  );

endinterface

// File: rtl/hpu_lsu_lsq.sv
// In-order load/store queue. Issued memory ops are buffered in a circular queue.
// Ops go to the D-cache one at a time from the head. Load data is aligned and
// extended. The LSQ also raises the load wake-up and reports misaligned accesses.
module hpu_lsu_lsq #(
  parameter int LSQ_LEN   = 8,
  parameter int LSQ_INDEX = 3,
  parameter int PHY_IDX_W = 6
) (
  input logic           clk_i,
  input logic           rst_i,
  hpu_lsu_lsq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  localparam int PTR_W = LSQ_INDEX + 1;

  state_e               state_q;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic                 drop_q;
  logic                 misalign_q;
  logic [31:0]          misalign_addr_q;
  logic                 wb_en_q;
  logic [PHY_IDX_W-1:0] wb_rdst_q;
  logic [31:0]          wb_data_q;

  logic                 ent_store_q [LSQ_LEN];
  logic [1:0]           ent_size_q  [LSQ_LEN];
  logic                 ent_uns_q   [LSQ_LEN];
  logic [31:0]          ent_addr_q  [LSQ_LEN];
  logic [31:0]          ent_wdata_q [LSQ_LEN];
  logic [PHY_IDX_W-1:0] ent_rdst_q  [LSQ_LEN];

  logic                 empty, full, enq, pop;
  logic [LSQ_INDEX-1:0] head_idx;
  logic                 head_store, head_uns, head_misalign;
  logic [1:0]           head_size;
  logic [31:0]          head_addr, head_wdata;
  logic [PHY_IDX_W-1:0] head_rdst;
  logic                 in_req, awake;
  logic [4:0]           shamt;
  logic [31:0]          shifted, load_data, req_wdata;
  logic [3:0]           req_be;

  // Queue status, head entry decode and the enqueue/pop decisions.
  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[LSQ_INDEX-1:0] == rd_ptr_q[LSQ_INDEX-1:0]) &&
               (wr_ptr_q[LSQ_INDEX] != rd_ptr_q[LSQ_INDEX]);
    enq      = bus.lsq_en_i && !full && !bus.flush_en_i;
    head_idx   = rd_ptr_q[LSQ_INDEX-1:0];
    head_store = ent_store_q[head_idx];
    head_size  = ent_size_q[head_idx];
    head_uns   = ent_uns_q[head_idx];
    head_addr  = ent_addr_q[head_idx];
    head_wdata = ent_wdata_q[head_idx];
    head_rdst  = ent_rdst_q[head_idx];
    head_misalign = ((head_size == 2'd1) && head_addr[0]) ||
                    (head_size[1] && (head_addr[1:0] != 2'b00));
    pop = 1'b0;
    if (!bus.flush_en_i) begin
      case (state_q)
        IDLE:    pop = !drop_q && !empty && head_misalign;
        REQ:     pop = bus.dc_ack_i && head_store;
        WAIT:    pop = bus.dc_rvld_i;
        default: pop = 1'b0;
      endcase
    end
    wr_ptr_d = bus.flush_en_i ? '0 : (enq ? wr_ptr_q + PTR_W'(1) : wr_ptr_q);
    rd_ptr_d = bus.flush_en_i ? '0 : (pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q);
    in_req   = (state_q == REQ);
    awake    = (state_q == WAIT) && bus.dc_rvld_i && !bus.flush_en_i;
  end

  // Byte enables and lane replication for the request, plus load data alignment and extension.
  always_comb begin
    req_be    = 4'hF;
    req_wdata = head_wdata;
    case (head_size)
      2'd0: begin
        req_be    = 4'b0001 << head_addr[1:0];
        req_wdata = {4{head_wdata[7:0]}};
      end
      2'd1: begin
        req_be    = 4'b0011 << {head_addr[1], 1'b0};
        req_wdata = {2{head_wdata[15:0]}};
      end
      default: begin
        req_be    = 4'hF;
        req_wdata = head_wdata;
      end
    endcase
    shamt     = {head_addr[1:0], 3'b000};
    shifted   = bus.dc_rdata_i >> shamt;
    load_data = shifted;
    case (head_size)
      2'd0:    load_data = head_uns ? {24'b0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    load_data = head_uns ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // Queue pointers: {wrap flag, index}, cleared by flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage is written only on enqueue. It needs no reset because it is only read when valid.
  always_ff @(posedge clk_i) begin
    if (enq) begin
      ent_store_q[wr_ptr_q[LSQ_INDEX-1:0]] <= bus.lsq_store_i;
      ent_size_q[wr_ptr_q[LSQ_INDEX-1:0]]  <= bus.lsq_size_i;
      ent_uns_q[wr_ptr_q[LSQ_INDEX-1:0]]   <= bus.lsq_unsigned_i;
      ent_addr_q[wr_ptr_q[LSQ_INDEX-1:0]]  <= bus.lsq_addr_i;
      ent_wdata_q[wr_ptr_q[LSQ_INDEX-1:0]] <= bus.lsq_wdata_i;
      ent_rdst_q[wr_ptr_q[LSQ_INDEX-1:0]]  <= bus.lsq_rdst_index_i;
    end
  end

  // Head sequencer: IDLE -> REQ -> (WAIT) -> IDLE. It also drops the response of a load flushed in flight and registers the wb/misalign outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      drop_q          <= 1'b0;
      misalign_q      <= 1'b0;
      misalign_addr_q <= '0;
      wb_en_q         <= 1'b0;
      wb_rdst_q       <= '0;
      wb_data_q       <= '0;
    end else begin
      misalign_q <= 1'b0;
      wb_en_q    <= awake;
      if (awake) begin
        wb_rdst_q <= head_rdst;
        wb_data_q <= load_data;
      end
      if (bus.flush_en_i) begin
        state_q <= IDLE;
        drop_q  <= (drop_q && !bus.dc_rvld_i) ||
                   ((state_q == WAIT) && !bus.dc_rvld_i) ||
                   ((state_q == REQ) && bus.dc_ack_i && !head_store);
      end else begin
        if (drop_q && bus.dc_rvld_i) begin
          drop_q <= 1'b0;
        end
        case (state_q)
          IDLE: begin
            if (!drop_q && !empty) begin
              if (head_misalign) begin
                misalign_q      <= 1'b1;
                misalign_addr_q <= head_addr;
              end else begin
                state_q <= REQ;
              end
            end
          end
          REQ: begin
            if (bus.dc_ack_i) begin
              state_q <= head_store ? IDLE : WAIT;
            end
          end
          WAIT: begin
            if (bus.dc_rvld_i) begin
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.lsq_stall_o            = full;
  assign bus.dc_req_o               = in_req && !bus.flush_en_i;
  assign bus.dc_we_o                = in_req && head_store;
  assign bus.dc_addr_o              = in_req ? {head_addr[31:2], 2'b00} : 32'h0;
  assign bus.dc_wdata_o             = in_req ? req_wdata : 32'h0;
  assign bus.dc_be_o                = in_req ? req_be : 4'h0;
  assign bus.laq_awake_en_o         = awake;
  assign bus.laq_awake_rdst_index_o = awake ? head_rdst : '0;
  assign bus.wb_en_o                = wb_en_q;
  assign bus.wb_rdst_index_o        = wb_rdst_q;
  assign bus.wb_data_o              = wb_data_q;
  assign bus.misalign_o             = misalign_q;
  assign bus.misalign_addr_o        = misalign_addr_q;

endmodule

// File: tb/tb_hpu_lsu_lsq.sv
// Directed, table-driven bench for hpu_lsu_lsq. Each table row holds one cycle of inputs
// and the outputs expected in that cycle. Hand-written sequences cover fill/wrap and flush.
module tb_hpu_lsu_lsq;

  typedef struct packed {
    logic        en;
    logic        st;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [5:0]  rdst;
    logic        ack;
    logic        rvld;
    logic [31:0] rdata;
    logic        flush;
  } in_t;

  typedef struct packed {
    logic        stall;
    logic        req;
    logic        we;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  be;
    logic        awk;
    logic [5:0]  awkIdx;
    logic        wb;
    logic [5:0]  wbIdx;
    logic [31:0] wbData;
    logic        mis;
    logic [31:0] misAddr;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } row_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  row_t vecs[$];

  always #5 clk = ~clk;

  hpu_lsu_lsq_if #(.PHY_IDX_W(6)) bus ();

  hpu_lsu_lsq #(.LSQ_LEN(8), .LSQ_INDEX(3), .PHY_IDX_W(6)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  function automatic in_t nop();
    in_t r = '0;
    return r;
  endfunction

  function automatic in_t opIn(logic st, logic [1:0] sz, logic uns, logic [31:0] a,
                               logic [31:0] wd, logic [5:0] rd);
    in_t r = '0;
    r.en = 1'b1; r.st = st; r.size = sz; r.uns = uns; r.addr = a; r.wdata = wd; r.rdst = rd;
    return r;
  endfunction

  function automatic in_t rspIn(logic ack, logic rvld, logic [31:0] rd);
    in_t r = '0;
    r.ack = ack; r.rvld = rvld; r.rdata = rd;
    return r;
  endfunction

  function automatic in_t withAck(in_t x);
    in_t r = x;
    r.ack = 1'b1;
    return r;
  endfunction

  function automatic in_t withFlush(in_t x);
    in_t r = x;
    r.flush = 1'b1;
    return r;
  endfunction

  function automatic exp_t eNone();
    exp_t r = '0;
    return r;
  endfunction

  function automatic exp_t eReq(logic we, logic [31:0] a, logic [31:0] wd, logic [3:0] be);
    exp_t r = '0;
    r.req = 1'b1; r.we = we; r.daddr = a; r.dwdata = wd; r.be = be;
    return r;
  endfunction

  function automatic exp_t eAwk(logic [5:0] idx);
    exp_t r = '0;
    r.awk = 1'b1; r.awkIdx = idx;
    return r;
  endfunction

  function automatic exp_t eWb(logic [5:0] idx, logic [31:0] d);
    exp_t r = '0;
    r.wb = 1'b1; r.wbIdx = idx; r.wbData = d;
    return r;
  endfunction

  function automatic exp_t eMis(logic [31:0] a);
    exp_t r = '0;
    r.mis = 1'b1; r.misAddr = a;
    return r;
  endfunction

  task automatic addRow(in_t i, exp_t e);
    row_t r;
    r.i = i;
    r.e = e;
    vecs.push_back(r);
  endtask

  task automatic applyStimulus(in_t s);
    bus.lsq_en_i         = s.en;
    bus.lsq_store_i      = s.st;
    bus.lsq_size_i       = s.size;
    bus.lsq_unsigned_i   = s.uns;
    bus.lsq_addr_i       = s.addr;
    bus.lsq_wdata_i      = s.wdata;
    bus.lsq_rdst_index_i = s.rdst;
    bus.dc_ack_i         = s.ack;
    bus.dc_rvld_i        = s.rvld;
    bus.dc_rdata_i       = s.rdata;
    bus.flush_en_i       = s.flush;
  endtask

  task automatic checkOutput(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
    end
  endtask

  task automatic checkRow(string tag, exp_t e);
    checkOutput({tag, " stall"}, 32'(bus.lsq_stall_o), 32'(e.stall));
    checkOutput({tag, " dc_req"}, 32'(bus.dc_req_o), 32'(e.req));
    checkOutput({tag, " awake"}, 32'(bus.laq_awake_en_o), 32'(e.awk));
    checkOutput({tag, " wb_en"}, 32'(bus.wb_en_o), 32'(e.wb));
    checkOutput({tag, " misalign"}, 32'(bus.misalign_o), 32'(e.mis));
    if (e.req) begin
      checkOutput({tag, " dc_we"}, 32'(bus.dc_we_o), 32'(e.we));
      checkOutput({tag, " dc_addr"}, bus.dc_addr_o, e.daddr);
      checkOutput({tag, " dc_wdata"}, bus.dc_wdata_o, e.dwdata);
      checkOutput({tag, " dc_be"}, 32'(bus.dc_be_o), 32'(e.be));
    end
    if (e.awk) checkOutput({tag, " awake_idx"}, 32'(bus.laq_awake_rdst_index_o), 32'(e.awkIdx));
    if (e.wb) begin
      checkOutput({tag, " wb_idx"}, 32'(bus.wb_rdst_index_o), 32'(e.wbIdx));
      checkOutput({tag, " wb_data"}, bus.wb_data_o, e.wbData);
    end
    if (e.mis) checkOutput({tag, " misalign_addr"}, bus.misalign_addr_o, e.misAddr);
  endtask

  task automatic runRow(string tag, in_t s, exp_t e);
    @(posedge clk);
    #1;
    applyStimulus(s);
    @(negedge clk);
    checkRow(tag, e);
  endtask

  // Hard time limit so the bench always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main test sequence: reset, vector table, fill/wrap, then the flush corner cases.
  initial begin
    logic [31:0] expAddr[$];
    int sent, popped, count, cyc;
    bit doEnq, didPop;
    in_t s;

    // Load word at 0x100, rdst 5, with rvld arriving three cycles after the ack.
    addRow(opIn(0, 2'd2, 0, 32'h100, 32'h0, 6'd5), eNone());
    addRow(nop(), eNone());
    addRow(rspIn(1, 0, 32'h0), eReq(0, 32'h100, 32'h0, 4'hF));
    addRow(nop(), eNone());
    addRow(nop(), eNone());
    addRow(rspIn(0, 1, 32'h800000F0), eAwk(6'd5));
    addRow(nop(), eWb(6'd5, 32'h800000F0));
    // Byte signed/unsigned at 0x103 and half unsigned at 0x102, enqueued back to back.
    addRow(opIn(0, 2'd0, 0, 32'h103, 32'h0, 6'd1), eNone());
    addRow(opIn(0, 2'd0, 1, 32'h103, 32'h0, 6'd2), eNone());
    addRow(withAck(opIn(0, 2'd1, 1, 32'h102, 32'h0, 6'd3)), eReq(0, 32'h100, 32'h0, 4'h8));
    addRow(rspIn(0, 1, 32'h80FFFFFF), eAwk(6'd1));
    addRow(nop(), eWb(6'd1, 32'hFFFFFF80));
    addRow(rspIn(1, 0, 32'h0), eReq(0, 32'h100, 32'h0, 4'h8));
    addRow(rspIn(0, 1, 32'h80FFFFFF), eAwk(6'd2));
    addRow(nop(), eWb(6'd2, 32'h00000080));
    addRow(rspIn(1, 0, 32'h0), eReq(0, 32'h100, 32'h0, 4'hC));
    addRow(rspIn(0, 1, 32'h80FFFFFF), eAwk(6'd3));
    addRow(nop(), eWb(6'd3, 32'h000080FF));
    // Signed half at 0x100.
    addRow(opIn(0, 2'd1, 0, 32'h100, 32'h0, 6'd6), eNone());
    addRow(nop(), eNone());
    addRow(rspIn(1, 0, 32'h0), eReq(0, 32'h100, 32'h0, 4'h3));
    addRow(rspIn(0, 1, 32'h12348001), eAwk(6'd6));
    addRow(nop(), eWb(6'd6, 32'hFFFF8001));
    // Store half at 0x206; the first REQ cycle has no ack, so the request must hold.
    addRow(opIn(1, 2'd1, 0, 32'h206, 32'hFFFF1234, 6'd0), eNone());
    addRow(nop(), eNone());
    addRow(nop(), eReq(1, 32'h204, 32'h12341234, 4'hC));
    addRow(rspIn(1, 0, 32'h0), eReq(1, 32'h204, 32'h12341234, 4'hC));
    addRow(nop(), eNone());
    // Store byte at 0x301.
    addRow(opIn(1, 2'd0, 0, 32'h301, 32'h000000AB, 6'd0), eNone());
    addRow(nop(), eNone());
    addRow(rspIn(1, 0, 32'h0), eReq(1, 32'h300, 32'hABABABAB, 4'h2));
    addRow(nop(), eNone());
    // Misaligned word at 0x102, followed by an aligned load that must issue next.
    addRow(opIn(0, 2'd2, 0, 32'h102, 32'h0, 6'd4), eNone());
    addRow(opIn(0, 2'd2, 0, 32'h200, 32'h0, 6'd7), eNone());
    addRow(nop(), eMis(32'h102));
    addRow(rspIn(1, 0, 32'h0), eReq(0, 32'h200, 32'h0, 4'hF));
    addRow(rspIn(0, 1, 32'h12345678), eAwk(6'd7));
    addRow(nop(), eWb(6'd7, 32'h12345678));

    rst = 1'b1;
    applyStimulus(nop());
    @(negedge clk);
    @(negedge clk);
    checkRow("reset", eNone());
    checkOutput("reset dc_be", 32'(bus.dc_be_o), 32'h0);
    checkOutput("reset dc_addr", bus.dc_addr_o, 32'h0);
    checkOutput("reset wb_data", bus.wb_data_o, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int r = 0; r < vecs.size(); r++) begin
      runRow($sformatf("vec%0d", r), vecs[r].i, vecs[r].e);
    end

    // Fill all eight slots with stores while ack is held low.
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      applyStimulus(opIn(1, 2'd2, 0, 32'h1000 + 32'(4 * k), 32'(k), 6'd0));
      expAddr.push_back(32'h1000 + 32'(4 * k));
      @(negedge clk);
      checkOutput($sformatf("fill%0d stall", k), 32'(bus.lsq_stall_o), 32'h0);
    end
    // A ninth op arrives while the queue is full and must be ignored.
    @(posedge clk);
    #1;
    applyStimulus(opIn(1, 2'd2, 0, 32'hDEAD0000, 32'h0, 6'd0));
    @(negedge clk);
    checkOutput("full stall", 32'(bus.lsq_stall_o), 32'h1);
    checkOutput("full head req", 32'(bus.dc_req_o), 32'h1);
    checkOutput("full head addr", bus.dc_addr_o, 32'h1000);

    // Drain with ack held high and refill from a model of occupancy, for 20 ops in total.
    sent = 8; popped = 0; count = 8; cyc = 0;
    while (popped < 20 && cyc < 200) begin
      @(posedge clk);
      #1;
      s = rspIn(1, 0, 32'h0);
      doEnq = (sent < 20) && (count < 8);
      if (doEnq) s = withAck(opIn(1, 2'd2, 0, 32'h1000 + 32'(4 * sent), 32'(sent), 6'd0));
      applyStimulus(s);
      @(negedge clk);
      checkOutput($sformatf("drain%0d stall", cyc), 32'(bus.lsq_stall_o), 32'(count == 8));
      didPop = 1'b0;
      if (bus.dc_req_o && bus.dc_ack_i) begin
        if (popped < expAddr.size()) begin
          checkOutput($sformatf("order%0d addr", popped), bus.dc_addr_o, expAddr[popped]);
        end else begin
          checkOutput($sformatf("order%0d extra", popped), bus.dc_addr_o, 32'hFFFFFFFF);
        end
        didPop = 1'b1;
        popped++;
      end
      if (doEnq) begin
        expAddr.push_back(32'h1000 + 32'(4 * sent));
        sent++;
        count++;
      end
      if (didPop) count--;
      cyc++;
    end
    checkOutput("drain pops", 32'(popped), 32'd20);
    runRow("postdrain", nop(), eNone());

    // Flush while a load waits in WAIT; the op offered in the flush cycle must not enter.
    runRow("fl0", opIn(0, 2'd2, 0, 32'h400, 32'h0, 6'd9), eNone());
    runRow("fl1", nop(), eNone());
    runRow("fl2", rspIn(1, 0, 32'h0), eReq(0, 32'h400, 32'h0, 4'hF));
    runRow("fl3", withFlush(opIn(0, 2'd2, 0, 32'h500, 32'h0, 6'd10)), eNone());
    runRow("fl4", rspIn(0, 1, 32'hAAAA5555), eNone());
    runRow("fl5", opIn(0, 2'd2, 0, 32'h600, 32'h0, 6'd11), eNone());
    runRow("fl6", nop(), eNone());
    runRow("fl7", rspIn(1, 0, 32'h0), eReq(0, 32'h600, 32'h0, 4'hF));
    runRow("fl8", rspIn(0, 1, 32'h0BADF00D), eAwk(6'd11));
    runRow("fl9", nop(), eWb(6'd11, 32'h0BADF00D));

    // Flush in REQ when a load is acked in the same cycle. The request is gated, and the
    // next load must wait until the stale response has been dropped.
    runRow("fr0", opIn(0, 2'd2, 0, 32'h700, 32'h0, 6'd12), eNone());
    runRow("fr1", nop(), eNone());
    runRow("fr2", withFlush(rspIn(1, 0, 32'h0)), eNone());
    runRow("fr3", opIn(0, 2'd2, 0, 32'h800, 32'h0, 6'd13), eNone());
    runRow("fr4", nop(), eNone());
    runRow("fr5", rspIn(0, 1, 32'h11111111), eNone());
    runRow("fr6", nop(), eNone());
    runRow("fr7", rspIn(1, 0, 32'h0), eReq(0, 32'h800, 32'h0, 4'hF));
    runRow("fr8", rspIn(0, 1, 32'h22222222), eAwk(6'd13));
    runRow("fr9", nop(), eWb(6'd13, 32'h22222222));

    applyStimulus(nop());
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
